uart_rx_8n1: RTL and testbench
==============================

UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, clk cycles per bit (12 MHz / 9600 baud); legal range 4..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  receiver enable; 0 = hold in IDLE.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rxbyte  output  8  last correctly framed byte.
REQ-007 rxdv  output  1  one-cycle pulse: rxbyte updated with a new byte.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 idle  output  1  high while FSM is in IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; the bit-period counter is 16 bits and the bit index is 3 bits.
REQ-012 IDLE: when en=1 and rx_s=0, go to START with counter cleared; otherwise remain in IDLE.
REQ-013 START: at counter = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s; if 0, go to DATA with counter and index cleared; if 1, treat as a glitch and return to IDLE with no output pulse.
REQ-014 DATA: at each counter = CLKS_PER_BIT - 1, sample rx_s into shift bit [index], LSB first, clear the counter, and increment index; after index 7, go to STOP.
REQ-015 STOP: at counter = CLKS_PER_BIT - 1, sample rx_s:
- if 1: load rxbyte from the shift register, pulse rxdv for exactly 1 cycle, and go to IDLE.
- if 0: pulse frame_err for 1 cycle, leave rxbyte unchanged, and go to BREAK.
REQ-016 BREAK: remain until rx_s=1, then go to IDLE; a held-low line SHALL NOT retrigger START.
REQ-017 rxdv and frame_err SHALL never be high in the same cycle, and neither SHALL be high for more than one consecutive cycle.
REQ-018 Latency: rxdv SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk cycles (+1 for input phase) after the rx falling edge reaches the input pin.
REQ-019 en deasserted in any non-IDLE state SHALL force IDLE on the next edge, with no rxdv/frame_err pulse and rxbyte unchanged.
REQ-020 A start edge arriving in the cycle in which IDLE is entered from STOP SHALL be accepted; back-to-back frames with a single stop bit SHALL all be received.
REQ-021 rxbyte SHALL hold its value between rxdv pulses; the shift register is internal and never visible mid-frame.
REQ-022 Sampling tolerance: a frame SHALL be received correctly with baud mismatch up to ±3% at CLKS_PER_BIT >= 16.

Reset
REQ-023 While rst_n=0: state = IDLE, counter = 0, index = 0, rxbyte = 8'h00, rxdv = 0, frame_err = 0, idle = 1, synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; after release, the FSM waits for a fresh falling edge on rx_s.

Verification (CLKS_PER_BIT = 16)
REQ-025 Send 0x55 then 0xA3 back-to-back, 8N1 -> two rxdv pulses, rxbyte = 0x55 then 0xA3, frame_err never high.
REQ-026 Send 0x3C with stop bit forced 0, line then held low for 40 cycles -> frame_err pulses once, rxbyte keeps its prior value, no START until rx returns high.
REQ-027 Drive a low glitch of 5 cycles on an idle line -> FSM returns to IDLE, no rxdv, no frame_err.
REQ-028 Drop en for 1 cycle during bit 4 of 0xFF -> no rxdv, idle = 1 on the next cycle; a following 0x81 is received correctly.
REQ-029 Assert rst_n=0 during the DATA state of 0x7E -> all outputs take their reset values immediately; the next frame 0x12 yields rxdv with rxbyte = 0x12.
REQ-030 Send 0x00 at bit period 15 and 17 cycles (±6%) and 0xC5 at 16.5 cycles -> 0xC5 is received correctly; REQ-018 latency checked on the nominal frame.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         receiver enable; low holds the FSM in IDLE
//   rx         serial line, idle high, asynchronous to clk
//   rxbyte     last correctly framed byte, held between rxdv pulses
//   rxdv       one-cycle pulse when rxbyte takes a new byte
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   idle       high while the FSM is in IDLE

module uart_rx_8n1 #(
   parameter int unsigned CLKS_PER_BIT = 1250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       rx,
   output logic [7:0] rxbyte,
   output logic       rxdv,
   output logic       frame_err,
   output logic       idle
);

   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  shift;
   logic        rx_q1;
   logic        rx_s;

   // Two-flop synchronizer; reset high so a reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_q1 <= rx;
         rx_s  <= rx_q1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 16'd0;
         idx       <= 3'd0;
         shift     <= 8'h00;
         rxbyte    <= 8'h00;
         rxdv      <= 1'b0;
         frame_err <= 1'b0;
         idle      <= 1'b1;
      end else begin
         rxdv      <= 1'b0;
         frame_err <= 1'b0;
         if (!en) begin
            // Disable aborts any frame in progress without reporting it.
            state <= IDLE;
            idle  <= 1'b1;
            cnt   <= 16'd0;
            idx   <= 3'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state <= START;
                     idle  <= 1'b0;
                     cnt   <= 16'd0;
                  end
               end
               START: begin
                  // Re-check the line half a bit in; a high here was a glitch.
                  if (cnt == HALF_LAST) begin
                     cnt <= 16'd0;
                     if (!rx_s) begin
                        state <= DATA;
                        idx   <= 3'd0;
                     end else begin
                        state <= IDLE;
                        idle  <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               DATA: begin
                  if (cnt == FULL_LAST) begin
                     shift[idx] <= rx_s;
                     cnt        <= 16'd0;
                     idx        <= idx + 3'd1;
                     if (idx == 3'd7) begin
                        state <= STOP;
                     end
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               STOP: begin
                  if (cnt == FULL_LAST) begin
                     cnt <= 16'd0;
                     if (rx_s) begin
                        rxbyte <= shift;
                        rxdv   <= 1'b1;
                        state  <= IDLE;
                        idle   <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                     end
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               BREAK: begin
                  // A held-low line must return high before a new start is looked for.
                  if (rx_s) begin
                     state <= IDLE;
                     idle  <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  idle  <= 1'b1;
                  cnt   <= 16'd0;
                  idx   <= 3'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - scoreboard bench for uart_rx_8n1 at 16 clocks per bit

module tb_uart_rx_8n1;

   localparam int CPB = 16;
   localparam int CLK_T = 20;
   localparam int BIT_T = CPB * CLK_T;
   // Posedges counted from the rx fall (made a quarter cycle after a posedge) to rxdv.
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      bit         chk_lat;
      int         fall_cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       rx;
   logic [7:0] rxbyte;
   logic       rxdv;
   logic       frame_err;
   logic       idle;

   exp_t q[$];
   int   total;
   int   bad;
   int   cyc;
   logic rxdv_prev;
   logic fe_prev;

   uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rx        (rx),
      .rxbyte    (rxbyte),
      .rxdv      (rxdv),
      .frame_err (frame_err),
      .idle      (idle)
   );

   initial clk = 1'b0;
   always #(CLK_T / 2) clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input int bit_t,
                             input bit push, input bit is_err, input logic [7:0] exp_byte,
                             input bit chk_lat);
      exp_t e;
      e.is_err   = is_err;
      e.data     = exp_byte;
      e.chk_lat  = chk_lat;
      e.fall_cyc = cyc;
      if (push) q.push_back(e);
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(bit_t);
      end
      rx = stop_b;
      #(bit_t);
   endtask

   // Monitor: pops one expected event per output pulse.
   initial begin
      rxdv_prev = 1'b0;
      fe_prev   = 1'b0;
      forever begin
         @(negedge clk);
         if (rxdv || frame_err) begin
            check("pulse_exclusive", {31'd0, rxdv & frame_err}, 32'd0);
            check("pulse_width", {31'd0, (rxdv & rxdv_prev) | (frame_err & fe_prev)}, 32'd0);
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse: rxdv=%0b frame_err=%0b rxbyte=%0h, expected none",
                        rxdv, frame_err, rxbyte);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
               check("rxbyte", {24'd0, rxbyte}, {24'd0, e.data});
               if (e.chk_lat) check("latency", cyc - e.fall_cyc, LAT);
            end
         end
         rxdv_prev = rxdv;
         fe_prev   = frame_err;
      end
   end

   initial begin
      int w;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      en    = 1'b0;
      rx    = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rxbyte", {24'd0, rxbyte}, 32'h00);
      check("rst_rxdv", {31'd0, rxdv}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_idle", {31'd0, idle}, 32'd1);
      @(posedge clk); #5;
      rst_n = 1'b1;
      en    = 1'b1;
      repeat (5) @(posedge clk);
      #5;

      // Back-to-back frames, nominal baud, latency checked
      send_frame(8'h55, 1'b1, BIT_T, 1, 0, 8'h55, 1);
      send_frame(8'hA3, 1'b1, BIT_T, 1, 0, 8'hA3, 1);
      repeat (20) @(posedge clk);
      #5;

      // Stop bit low then line held low: one frame_err, rxbyte keeps 0xA3
      send_frame(8'h3C, 1'b0, BIT_T, 1, 1, 8'hA3, 0);
      #(40 * CLK_T);
      @(negedge clk);
      check("break_not_idle", {31'd0, idle}, 32'd0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("break_exit_idle", {31'd0, idle}, 32'd1);

      // 5-cycle glitch
      @(posedge clk); #5;
      rx = 1'b0;
      #(5 * CLK_T);
      rx = 1'b1;
      @(negedge clk);
      check("glitch_start_seen", {31'd0, idle}, 32'd0);
      repeat (15) @(negedge clk);
      check("glitch_back_idle", {31'd0, idle}, 32'd1);

      // en dropped for one cycle in bit 4 of 0xFF, then 0x81
      @(posedge clk); #5;
      fork
         send_frame(8'hFF, 1'b1, BIT_T, 0, 0, 8'h00, 0);
         begin
            #(BIT_T * 5 + BIT_T / 2);
            check("en_drop_busy", {31'd0, idle}, 32'd0);
            en = 1'b0;
            @(posedge clk); #5;
            en = 1'b1;
            @(negedge clk);
            check("en_drop_idle", {31'd0, idle}, 32'd1);
         end
      join
      repeat (10) @(posedge clk);
      #5;
      send_frame(8'h81, 1'b1, BIT_T, 1, 0, 8'h81, 1);
      repeat (10) @(posedge clk);
      #5;

      // Reset during DATA of 0x7E
      rx = 1'b0;
      #(BIT_T);
      rx = 1'b0;
      #(BIT_T);
      rx = 1'b1;
      #(BIT_T);
      rx = 1'b1;
      #(BIT_T);
      rx = 1'b1;
      #(BIT_T / 2);
      rst_n = 1'b0;
      #1;
      check("midrst_rxbyte", {24'd0, rxbyte}, 32'h00);
      check("midrst_rxdv", {31'd0, rxdv}, 32'd0);
      check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      check("midrst_idle", {31'd0, idle}, 32'd1);
      rx = 1'b1;
      repeat (10) @(posedge clk);
      #5;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #5;
      send_frame(8'h12, 1'b1, BIT_T, 1, 0, 8'h12, 1);
      repeat (20) @(posedge clk);
      #5;

      // Baud mismatch: 15 cycles shifts bits 6/7 -> 0x80; 17 cycles misses the stop bit
      send_frame(8'h00, 1'b1, 15 * CLK_T, 1, 0, 8'h80, 0);
      repeat (30) @(posedge clk);
      #5;
      send_frame(8'h00, 1'b1, 17 * CLK_T, 1, 1, 8'h80, 0);
      repeat (30) @(posedge clk);
      #5;
      send_frame(8'hC5, 1'b1, 33 * CLK_T / 2, 1, 0, 8'hC5, 0);
      repeat (30) @(posedge clk);

      w = 0;
      while (q.size() != 0 && w < 4000) begin
         @(negedge clk);
         w++;
      end
      check("all_events_seen", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
